// File: rtl/ddr3_responder.sv
// ddr3_responder: responder end of the DDRAM burst interface, backed by an
// on-chip RAM of 64-bit words. It accepts write bursts under byte enables and
// returns read bursts after a fixed latency. It also keeps saturating or
// wrapping counters of protocol violations and of beats moved.
// Optional build macro DDR3_RESP_STALL_EN adds LFSR-driven random BUSY
// back-pressure in IDLE and WRITE.
module ddr3_responder #(
    parameter int          ADDR_BITS  = 10,
    parameter int          RD_LATENCY = 8,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ddr3_BUSY,
    input  logic [7:0]  ddr3_BURSTCNT,
    input  logic [28:0] ddr3_ADDR,
    input  logic        ddr3_RD,
    input  logic        ddr3_WE,
    input  logic [63:0] ddr3_DIN,
    input  logic [7:0]  ddr3_BE,
    output logic [63:0] ddr3_DOUT,
    output logic        ddr3_DOUT_READY,
    output logic [15:0] proto_err,
    output logic [31:0] beats_wr,
    output logic [31:0] beats_rd
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        RD_WAIT,
        RD_BURST
    } state_t;

    localparam int            DEPTH    = 1 << ADDR_BITS;
    localparam logic [7:0]    LAT_INIT = 8'(RD_LATENCY - 1);

    state_t                 state_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [7:0]             cnt_q;
    logic [7:0]             lat_q;
    logic                   busy_q;
    logic [63:0]            dout_q;
    logic                   ready_q;
    logic [15:0]            proto_err_q;
    logic [15:0]            proto_err_d;
    logic [31:0]            beats_wr_q;
    logic [31:0]            beats_rd_q;

    logic [63:0]            mem [DEPTH];

    logic                   stall_d;
    logic [7:0]             cmd_cnt;
    logic [1:0]             err_inc;
    logic [16:0]            err_sum;
    logic                   wr_en;
    logic [ADDR_BITS-1:0]   wr_addr;

    // Only the low ADDR_BITS of the word address select a RAM word.
    logic unused_addr;
    assign unused_addr = ^ddr3_ADDR[28:ADDR_BITS];

`ifdef DDR3_RESP_STALL_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Fibonacci LFSR, taps 16,14,13,11; BUSY follows the value being loaded.
    assign lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign stall_d = (lfsr_d[1:0] == 2'b00);

    // Stall LFSR advances every cycle, restarting from the seed on reset.
    always_ff @(posedge clk) begin
        if (reset) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= lfsr_d;
    end
`else
    logic unused_seed;
    assign unused_seed = ^LFSR_SEED;
    assign stall_d     = 1'b0;
`endif

    // Command decode: zero-length bursts act as one beat; count violations.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        cmd_cnt = (ddr3_BURSTCNT == 8'd0) ? 8'd1 : ddr3_BURSTCNT;
        err_inc = 2'd0;
        wr_en   = 1'b0;
        wr_addr = addr_q;
        if (!reset && !busy_q) begin
            case (state_q)
                IDLE: begin
                    if (ddr3_WE || ddr3_RD) begin
                        err_inc = {1'b0, ddr3_WE & ddr3_RD} + {1'b0, ddr3_BURSTCNT == 8'd0};
                    end
                    if (ddr3_WE) begin
                        wr_en   = 1'b1;
                        wr_addr = ddr3_ADDR[ADDR_BITS-1:0];
                    end
                end
                WRITE: begin
                    if (ddr3_RD) err_inc = 2'd1;
                    wr_en = ddr3_WE;
                end
                default: ;
            endcase
        end
        err_sum     = {1'b0, proto_err_q} + 17'(err_inc);
        proto_err_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    // Backing RAM write port with per-byte enables.
    always_ff @(posedge clk) begin
        // NOTE: the RAM array has no reset so it maps onto block RAM; contents survive reset.
        if (wr_en) begin
            for (int b = 0; b < 8; b++) begin
                if (ddr3_BE[b]) mem[wr_addr][8*b +: 8] <= ddr3_DIN[8*b +: 8];
            end
        end
    end

    // Protocol FSM with registered BUSY, read data, beat strobe and counters.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every read sees the pre-edge value.
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            lat_q       <= '0;
            busy_q      <= 1'b1;
            dout_q      <= '0;
            ready_q     <= 1'b0;
            proto_err_q <= '0;
            beats_wr_q  <= '0;
            beats_rd_q  <= '0;
        end else begin
            proto_err_q <= proto_err_d;
            ready_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    busy_q <= stall_d;
                    if (!busy_q && ddr3_WE) begin
                        addr_q     <= ddr3_ADDR[ADDR_BITS-1:0] + ADDR_BITS'(1);
                        cnt_q      <= cmd_cnt - 8'd1;
                        beats_wr_q <= beats_wr_q + 32'd1;
                        if (cmd_cnt != 8'd1) state_q <= WRITE;
                    end else if (!busy_q && ddr3_RD) begin
                        addr_q  <= ddr3_ADDR[ADDR_BITS-1:0];
                        cnt_q   <= cmd_cnt;
                        lat_q   <= LAT_INIT;
                        busy_q  <= 1'b1;
                        state_q <= RD_WAIT;
                    end
                end
                WRITE: begin
                    busy_q <= stall_d;
                    if (!busy_q && ddr3_WE) begin
                        addr_q     <= addr_q + ADDR_BITS'(1);
                        cnt_q      <= cnt_q - 8'd1;
                        beats_wr_q <= beats_wr_q + 32'd1;
                        if (cnt_q == 8'd1) state_q <= IDLE;
                    end
                end
                RD_WAIT: begin
                    busy_q <= 1'b1;
                    if (lat_q == 8'd0) begin
                        dout_q     <= mem[addr_q];
                        ready_q    <= 1'b1;
                        addr_q     <= addr_q + ADDR_BITS'(1);
                        cnt_q      <= cnt_q - 8'd1;
                        beats_rd_q <= beats_rd_q + 32'd1;
                        state_q    <= RD_BURST;
                    end else begin
                        lat_q <= lat_q - 8'd1;
                    end
                end
                RD_BURST: begin
                    if (cnt_q == 8'd0) begin
                        busy_q  <= stall_d;
                        state_q <= IDLE;
                    end else begin
                        busy_q     <= 1'b1;
                        dout_q     <= mem[addr_q];
                        ready_q    <= 1'b1;
                        addr_q     <= addr_q + ADDR_BITS'(1);
                        cnt_q      <= cnt_q - 8'd1;
                        beats_rd_q <= beats_rd_q + 32'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ddr3_BUSY       = busy_q;
    assign ddr3_DOUT       = dout_q;
    assign ddr3_DOUT_READY = ready_q;
    assign proto_err       = proto_err_q;
    assign beats_wr        = beats_wr_q;
    assign beats_rd        = beats_rd_q;

endmodule

// File: tb/tb_ddr3_responder.sv
// tb_ddr3_responder: self-checking bench for ddr3_responder. A behavioural
// model (word array, beat and error counts) predicts read data, beat timing
// and counter values for directed and randomized write/read traffic.
module tb_ddr3_responder;

    localparam int L     = 8;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        ddr3_BUSY;
    logic [7:0]  ddr3_BURSTCNT;
    logic [28:0] ddr3_ADDR;
    logic        ddr3_RD;
    logic        ddr3_WE;
    logic [63:0] ddr3_DIN;
    logic [7:0]  ddr3_BE;
    logic [63:0] ddr3_DOUT;
    logic        ddr3_DOUT_READY;
    logic [15:0] proto_err;
    logic [31:0] beats_wr;
    logic [31:0] beats_rd;

    ddr3_responder dut (
        .clk             (clk),
        .reset           (reset),
        .ddr3_BUSY       (ddr3_BUSY),
        .ddr3_BURSTCNT   (ddr3_BURSTCNT),
        .ddr3_ADDR       (ddr3_ADDR),
        .ddr3_RD         (ddr3_RD),
        .ddr3_WE         (ddr3_WE),
        .ddr3_DIN        (ddr3_DIN),
        .ddr3_BE         (ddr3_BE),
        .ddr3_DOUT       (ddr3_DOUT),
        .ddr3_DOUT_READY (ddr3_DOUT_READY),
        .proto_err       (proto_err),
        .beats_wr        (beats_wr),
        .beats_rd        (beats_rd)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state.
    logic [63:0] model_mem [DEPTH];
    int unsigned exp_wr  = 0;
    int unsigned exp_rd  = 0;
    int unsigned exp_err = 0;
    int          busy_idle_seen = 0;

    // Per-burst stimulus and capture buffers.
    logic [63:0] wdata [256];
    logic [7:0]  wbe   [256];
    logic [63:0] rd_capture [256];
    int          rd_beats_seen;

    function automatic logic [63:0] merge(input logic [63:0] old_w, input logic [63:0] new_w,
                                          input logic [7:0] be);
        logic [63:0] r;
        r = old_w;
        for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one write burst; beats stalled by BUSY are held and retried.
    task automatic write_burst(input logic [28:0] addr, input logic [7:0] bc,
                               input logic with_rd, input bit gaps);
        int n;
        int i;
        int guard;
        int a;
        logic acc;
        n = (bc == 8'd0) ? 1 : int'(bc);
        i = 0;
        guard = 0;
        while (i < n && guard < 20000) begin
            if (gaps && i > 0 && $urandom_range(0, 3) == 0) begin
                ddr3_WE = 1'b0;
                ddr3_RD = 1'b0;
                tick();
                guard++;
            end else begin
                ddr3_WE       = 1'b1;
                ddr3_RD       = with_rd;
                ddr3_ADDR     = addr;
                ddr3_BURSTCNT = bc;
                ddr3_DIN      = wdata[i];
                ddr3_BE       = wbe[i];
                acc = (ddr3_BUSY === 1'b0);
                if (ddr3_BUSY === 1'b1 && i == 0) busy_idle_seen++;
                tick();
                guard++;
                if (acc) begin
                    a = (int'(addr[9:0]) + i) % DEPTH;
                    model_mem[a] = merge(model_mem[a], wdata[i], wbe[i]);
                    exp_wr++;
                    if (with_rd) exp_err++;
                    if (i == 0 && bc == 8'd0) exp_err++;
                    i++;
                end
            end
        end
        ddr3_WE = 1'b0;
        ddr3_RD = 1'b0;
        tests_run++;
        if (i != n) begin
            tests_failed++;
            $display("FAIL write_timeout: accepted %0d beats, required %0d", i, n);
        end
    endtask

    // Issue a read and check every cycle until the responder is idle again.
    task automatic read_burst(input logic [28:0] addr, input logic [7:0] bc, input int abort_beat);
        int n;
        int guard;
        int a;
        logic exp_ready;
        n = (bc == 8'd0) ? 1 : int'(bc);
        guard = 0;
        while (ddr3_BUSY !== 1'b0 && guard < 1000) begin
            tick();
            guard++;
        end
        tests_run++;
        if (ddr3_BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_accept_timeout: BUSY=%b, required 0", ddr3_BUSY);
            return;
        end
        ddr3_RD       = 1'b1;
        ddr3_WE       = 1'b0;
        ddr3_ADDR     = addr;
        ddr3_BURSTCNT = bc;
        tick();
        ddr3_RD = 1'b0;
        if (bc == 8'd0) exp_err++;
        rd_beats_seen = 0;
        for (int k = 0; k <= L + n; k++) begin
            if (k > 0) tick();
            exp_ready = (k >= L) && (k < L + n);
            tests_run++;
            if (ddr3_DOUT_READY !== exp_ready) begin
                tests_failed++;
                $display("FAIL rd_ready cycle %0d: got %b, required %b", k, ddr3_DOUT_READY, exp_ready);
            end
            if (ddr3_DOUT_READY === 1'b1 && rd_beats_seen < 256) begin
                rd_capture[rd_beats_seen] = ddr3_DOUT;
                rd_beats_seen++;
            end
            if (exp_ready) begin
                a = (int'(addr[9:0]) + k - L) % DEPTH;
                exp_rd++;
                tests_run++;
                if (ddr3_DOUT !== model_mem[a]) begin
                    tests_failed++;
                    $display("FAIL rd_data addr %0d: got %h, required %h", a, ddr3_DOUT, model_mem[a]);
                end
            end
            if (k < L + n) begin
                tests_run++;
                if (ddr3_BUSY !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL rd_busy cycle %0d: got %b, required 1", k, ddr3_BUSY);
                end
            end
`ifndef DDR3_RESP_STALL_EN
            else begin
                tests_run++;
                if (ddr3_BUSY !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL rd_busy_release: got %b, required 0", ddr3_BUSY);
                end
            end
`endif
            if (abort_beat > 0 && exp_ready && (k - L + 1) == abort_beat) return;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        tests_run += 6;
        if (ddr3_BUSY !== 1'b1) begin tests_failed++; $display("FAIL reset_busy: got %b, required 1", ddr3_BUSY); end
        if (ddr3_DOUT_READY !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b, required 0", ddr3_DOUT_READY); end
        if (ddr3_DOUT !== 64'd0) begin tests_failed++; $display("FAIL reset_dout: got %h, required 0", ddr3_DOUT); end
        if (proto_err !== 16'd0) begin tests_failed++; $display("FAIL reset_proto_err: got %0d, required 0", proto_err); end
        if (beats_wr !== 32'd0) begin tests_failed++; $display("FAIL reset_beats_wr: got %0d, required 0", beats_wr); end
        if (beats_rd !== 32'd0) begin tests_failed++; $display("FAIL reset_beats_rd: got %0d, required 0", beats_rd); end
        reset = 1'b0;
        tick();
        tests_run++;
        if (ddr3_BUSY !== 1'b0) begin tests_failed++; $display("FAIL reset_release_busy: got %b, required 0", ddr3_BUSY); end
        exp_wr = 0;
        exp_rd = 0;
        exp_err = 0;
    endtask

    task automatic test_single();
        wdata[0] = 64'h1122334455667788;
        wbe[0]   = 8'hFF;
        write_burst(29'd5, 8'd1, 1'b0, 1'b0);
        read_burst(29'd5, 8'd1, 0);
        tests_run += 4;
        if (rd_beats_seen != 1) begin tests_failed++; $display("FAIL single_beats: got %0d, required 1", rd_beats_seen); end
        if (rd_capture[0] !== 64'h1122334455667788) begin tests_failed++; $display("FAIL single_data: got %h, required 1122334455667788", rd_capture[0]); end
        if (beats_wr !== 32'd1) begin tests_failed++; $display("FAIL single_beats_wr: got %0d, required 1", beats_wr); end
        if (beats_rd !== 32'd1) begin tests_failed++; $display("FAIL single_beats_rd: got %0d, required 1", beats_rd); end
    endtask

    task automatic test_burst_be();
        for (int i = 0; i < 4; i++) begin
            wdata[i] = 64'hFFFF_FFFF_FFFF_FFFF;
            wbe[i]   = 8'hFF;
        end
        write_burst(29'd1022, 8'd4, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            wdata[i] = 64'(i);
            wbe[i]   = (i == 2) ? 8'h0F : 8'hFF;
        end
        write_burst(29'd1022, 8'd4, 1'b0, 1'b0);
        read_burst(29'd1022, 8'd4, 0);
        tests_run += 4;
        if (rd_capture[0] !== 64'd0) begin tests_failed++; $display("FAIL be_beat0: got %h, required 0", rd_capture[0]); end
        if (rd_capture[1] !== 64'd1) begin tests_failed++; $display("FAIL be_beat1: got %h, required 1", rd_capture[1]); end
        if (rd_capture[2] !== 64'hFFFFFFFF00000002) begin tests_failed++; $display("FAIL be_beat2: got %h, required ffffffff00000002", rd_capture[2]); end
        if (rd_capture[3] !== 64'd3) begin tests_failed++; $display("FAIL be_beat3: got %h, required 3", rd_capture[3]); end
    endtask

    // Fill the whole RAM with known data so later random reads are defined.
    task automatic test_fill();
        for (int blk = 0; blk < DEPTH / 128; blk++) begin
            for (int i = 0; i < 128; i++) begin
                wdata[i] = {$urandom, $urandom};
                wbe[i]   = 8'hFF;
            end
            write_burst(29'(blk * 128), 8'd128, 1'b0, 1'b0);
        end
        tests_run++;
        if (beats_wr !== exp_wr) begin tests_failed++; $display("FAIL fill_beats_wr: got %0d, required %0d", beats_wr, exp_wr); end
    endtask

    task automatic test_read_timing();
        read_burst(29'($urandom_range(0, DEPTH - 1)), 8'd128, 0);
        tests_run++;
        if (rd_beats_seen != 128) begin tests_failed++; $display("FAIL timing_beats: got %0d, required 128", rd_beats_seen); end
    endtask

    task automatic test_proto_err();
        logic [28:0] a;
        a = 29'd300;
        wdata[0] = {$urandom, $urandom};
        wbe[0]   = 8'hFF;
        write_burst(a, 8'd1, 1'b1, 1'b0);
        read_burst(a, 8'd0, 0);
        tests_run += 3;
        if (proto_err !== 16'd2) begin tests_failed++; $display("FAIL proto_err_count: got %0d, required 2", proto_err); end
        if (rd_beats_seen != 1) begin tests_failed++; $display("FAIL proto_zero_len_beats: got %0d, required 1", rd_beats_seen); end
        if (rd_capture[0] !== wdata[0]) begin tests_failed++; $display("FAIL proto_write_stored: got %h, required %h", rd_capture[0], wdata[0]); end
    endtask

    task automatic test_reset_mid_read();
        read_burst(29'd512, 8'd64, 10);
        reset = 1'b1;
        tick();
        tests_run += 2;
        if (ddr3_DOUT_READY !== 1'b0) begin tests_failed++; $display("FAIL midreset_ready: got %b, required 0", ddr3_DOUT_READY); end
        if (ddr3_BUSY !== 1'b1) begin tests_failed++; $display("FAIL midreset_busy: got %b, required 1", ddr3_BUSY); end
        tick();
        reset = 1'b0;
        tick();
        exp_wr = 0;
        exp_rd = 0;
        exp_err = 0;
        tests_run++;
        if (ddr3_BUSY !== 1'b0) begin tests_failed++; $display("FAIL midreset_release_busy: got %b, required 0", ddr3_BUSY); end
        read_burst(29'd700, 8'd4, 0);
        tests_run += 2;
        if (beats_rd !== 32'd4) begin tests_failed++; $display("FAIL midreset_beats_rd: got %0d, required 4", beats_rd); end
        if (beats_wr !== 32'd0) begin tests_failed++; $display("FAIL midreset_beats_wr: got %0d, required 0", beats_wr); end
    endtask

    task automatic test_random();
        int n_cmds;
        logic [28:0] a;
        logic [7:0]  bc;
`ifdef DDR3_RESP_STALL_EN
        n_cmds = 1000;
`else
        n_cmds = 300;
`endif
        busy_idle_seen = 0;
        for (int c = 0; c < n_cmds; c++) begin
            a  = 29'($urandom);
            bc = 8'($urandom_range(1, 16));
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i < int'(bc); i++) begin
                    wdata[i] = {$urandom, $urandom};
                    wbe[i]   = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
                end
                write_burst(a, bc, 1'b0, 1'b1);
            end else begin
                read_burst(a, bc, 0);
            end
        end
        tests_run += 3;
        if (beats_wr !== exp_wr) begin tests_failed++; $display("FAIL random_beats_wr: got %0d, required %0d", beats_wr, exp_wr); end
        if (beats_rd !== exp_rd) begin tests_failed++; $display("FAIL random_beats_rd: got %0d, required %0d", beats_rd, exp_rd); end
        if (32'(proto_err) !== exp_err) begin tests_failed++; $display("FAIL random_proto_err: got %0d, required %0d", proto_err, exp_err); end
`ifdef DDR3_RESP_STALL_EN
        tests_run++;
        if (busy_idle_seen == 0) begin tests_failed++; $display("FAIL stall_seen: got %0d idle stalls, required at least 1", busy_idle_seen); end
`endif
    endtask

    initial begin
        reset         = 1'b1;
        ddr3_RD       = 1'b0;
        ddr3_WE       = 1'b0;
        ddr3_ADDR     = '0;
        ddr3_BURSTCNT = '0;
        ddr3_DIN      = '0;
        ddr3_BE       = '0;
        test_reset();
        test_single();
        test_burst_be();
        test_fill();
        test_read_timing();
        test_proto_err();
        test_reset_mid_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
